// File: rtl/pueo_trig_pkg.sv
// Shared types and default sizing for the PUEO trigger holdoff controller.
// Provides the FSM state type and default parameter values.
package pueo_trig_pkg;

    localparam int DEF_NBUF      = 4;
    localparam int DEF_HOLDOFF_W = 16;
    localparam int DEF_CNT_W     = 32;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        HOLDOFF  = 2'd2
    } trig_ctrl_state_t;

endpackage

// File: rtl/pueo_trig_holdoff_ctrl_if.sv
// Control/status bundle between the L2 side and the trigger holdoff controller.
// master: drives ce/run/trig/holdoff_len/done/cnt_clear; slave: returns
// trig/holdoff/dead/occupancy/counters/underflow.
interface pueo_trig_holdoff_ctrl_if
    import pueo_trig_pkg::*;
#(
    parameter int NBUF      = DEF_NBUF,
    parameter int HOLDOFF_W = DEF_HOLDOFF_W,
    parameter int CNT_W     = DEF_CNT_W
);
    localparam int OCC_W = $clog2(NBUF + 1);

    logic                 ce_i;
    logic                 run_i;
    logic                 trig_i;
    logic [HOLDOFF_W-1:0] holdoff_len_i;
    logic                 done_i;
    logic                 cnt_clear_i;
    logic                 trig_o;
    logic                 holdoff_o;
    logic                 dead_o;
    logic [OCC_W-1:0]     occupancy_o;
    logic [CNT_W-1:0]     trig_count_o;
    logic [CNT_W-1:0]     dead_count_o;
    logic                 underflow_o;

    modport master (
        output ce_i, run_i, trig_i, holdoff_len_i, done_i, cnt_clear_i,
        input  trig_o, holdoff_o, dead_o, occupancy_o,
        input  trig_count_o, dead_count_o, underflow_o
    );

    modport slave (
        input  ce_i, run_i, trig_i, holdoff_len_i, done_i, cnt_clear_i,
        output trig_o, holdoff_o, dead_o, occupancy_o,
        output trig_count_o, dead_count_o, underflow_o
    );

endinterface

// File: rtl/pueo_sat_counter.sv
// Up-counter with synchronous clear; SAT=1 holds at all-ones, SAT=0 wraps.
// Ports: clk_i, rst_i (async high), clr_i, inc_i, cnt_o[W].
module pueo_sat_counter #(
    parameter int W   = 32,
    parameter bit SAT = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;
    logic         w_hold;

    // Saturating mode freezes once every bit is set.
    assign w_hold = SAT && (&r_cnt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && !w_hold) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pueo_trig_holdoff_ctrl.sv
// Trigger admission: holdoff after each accepted trigger, buffer occupancy
// tracking, dead/holdoff feedback to L2, trigger and deadtime counters.
// Ports: clk_i, rst_i (async high), bus (slave side of the control bundle).
module pueo_trig_holdoff_ctrl
    import pueo_trig_pkg::*;
#(
    parameter int NBUF      = DEF_NBUF,
    parameter int HOLDOFF_W = DEF_HOLDOFF_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    pueo_trig_holdoff_ctrl_if.slave  bus
);

    localparam int              OCC_W = $clog2(NBUF + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(NBUF);

    trig_ctrl_state_t     r_state;
    logic [HOLDOFF_W-1:0] r_hcnt;
    logic [OCC_W-1:0]     r_occ;
    logic                 r_trig;
    logic                 r_holdoff;
    logic                 r_dead;
    logic                 r_underflow;

    trig_ctrl_state_t     w_state_nx;
    logic [HOLDOFF_W-1:0] w_hcnt_nx;
    logic [OCC_W-1:0]     w_occ_nx;
    logic                 w_full;
    logic                 w_accept;
    logic                 w_uflow;
    logic                 w_dead_inc;

    assign w_full   = (r_occ == FULL);
    // run_i low takes priority over a coincident trigger.
    assign w_accept = bus.ce_i & bus.run_i & bus.trig_i
                    & (r_state == ARMED) & ~w_full;

    always_comb begin
        w_state_nx = r_state;
        w_hcnt_nx  = r_hcnt;
        if (bus.ce_i) begin
            if (!bus.run_i) begin
                w_state_nx = DISARMED;
                w_hcnt_nx  = '0;
            end else begin
                case (r_state)
                    DISARMED: w_state_nx = ARMED;
                    ARMED: begin
                        if (w_accept) begin
                            w_state_nx = HOLDOFF;
                            w_hcnt_nx  = bus.holdoff_len_i;
                        end
                    end
                    HOLDOFF: begin
                        // count==0 still spends this tick in HOLDOFF.
                        if (r_hcnt == '0) begin
                            w_state_nx = ARMED;
                        end else begin
                            w_hcnt_nx = r_hcnt - HOLDOFF_W'(1);
                        end
                    end
                    default: w_state_nx = DISARMED;
                endcase
            end
        end
    end

    // done_i acts on every clk; accept+done cancel out.
    always_comb begin
        w_occ_nx = r_occ;
        w_uflow  = 1'b0;
        if (w_accept && !bus.done_i) begin
            w_occ_nx = r_occ + OCC_W'(1);
        end else if (!w_accept && bus.done_i) begin
            if (r_occ == '0) begin
                w_uflow = 1'b1;
            end else begin
                w_occ_nx = r_occ - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= DISARMED;
            r_hcnt      <= '0;
            r_occ       <= '0;
            r_trig      <= 1'b0;
            r_holdoff   <= 1'b0;
            r_dead      <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_hcnt      <= w_hcnt_nx;
            r_occ       <= w_occ_nx;
            r_trig      <= w_accept;
            r_holdoff   <= (w_state_nx == HOLDOFF);
            r_dead      <= (w_state_nx == DISARMED) | (w_occ_nx == FULL);
            r_underflow <= r_underflow | w_uflow;
        end
    end

    assign w_dead_inc = bus.ce_i & (r_dead | r_holdoff);

    pueo_sat_counter #(
        .W   (CNT_W),
        .SAT (1'b0)
    ) u_trig_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.cnt_clear_i),
        .inc_i (w_accept),
        .cnt_o (bus.trig_count_o)
    );

    pueo_sat_counter #(
        .W   (CNT_W),
        .SAT (1'b1)
    ) u_dead_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (bus.cnt_clear_i),
        .inc_i (w_dead_inc),
        .cnt_o (bus.dead_count_o)
    );

    assign bus.trig_o      = r_trig;
    assign bus.holdoff_o   = r_holdoff;
    assign bus.dead_o      = r_dead;
    assign bus.occupancy_o = r_occ;
    assign bus.underflow_o = r_underflow;

endmodule

// File: tb/tb_pueo_trig_holdoff_ctrl.sv
// Self-checking bench for pueo_trig_holdoff_ctrl: directed scenarios plus
// randomized traffic against a behavioural model of the admission rules.
module tb_pueo_trig_holdoff_ctrl;

    localparam int NBUF  = 4;
    localparam int HW    = 16;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pueo_trig_holdoff_ctrl_if #(.NBUF(NBUF), .HOLDOFF_W(HW), .CNT_W(CW)) bus ();

    pueo_trig_holdoff_ctrl #(.NBUF(NBUF), .HOLDOFF_W(HW), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: armed flag, holdoff ticks still to spend, outstanding events.
    bit m_armed;
    int m_left;
    int m_occ;
    bit m_uf;
    int m_tc;
    int m_dc;
    bit e_trig;
    bit e_hold;
    bit e_dead;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0;
        m_left  = 0;
        m_occ   = 0;
        m_uf    = 0;
        m_tc    = 0;
        m_dc    = 0;
        e_trig  = 0;
        e_hold  = 0;
        e_dead  = 1;
    endtask

    task automatic model_step(input bit ce, input bit run, input bit trig,
                              input int len, input bit done, input bit clr);
        bit acc;
        bit dinc;
        acc  = ce && run && m_armed && (m_left == 0) && trig && (m_occ < NBUF);
        dinc = ce && (e_dead || e_hold);
        if (ce) begin
            if (!run) begin
                m_armed = 0;
                m_left  = 0;
            end else if (!m_armed) begin
                m_armed = 1;
            end else if (acc) begin
                m_left = len + 1;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        if (acc && !done) m_occ++;
        else if (!acc && done) begin
            if (m_occ == 0) m_uf = 1;
            else m_occ--;
        end
        if (clr) begin
            m_tc = 0;
            m_dc = 0;
        end else begin
            m_tc = (m_tc + int'(acc)) % (CMAX + 1);
            if (dinc && m_dc < CMAX) m_dc++;
        end
        e_trig = acc;
        e_hold = (m_left > 0);
        e_dead = !m_armed || (m_occ == NBUF);
    endtask

    task automatic check_all();
        chk("trig_o", bus.trig_o, e_trig);
        chk("holdoff_o", bus.holdoff_o, e_hold);
        chk("dead_o", bus.dead_o, e_dead);
        chk("occupancy_o", bus.occupancy_o, m_occ);
        chk("underflow_o", bus.underflow_o, m_uf);
        chk("trig_count_o", bus.trig_count_o, m_tc);
        chk("dead_count_o", bus.dead_count_o, m_dc);
    endtask

    task automatic tick(input bit ce, input bit run, input bit trig,
                        input int len, input bit done, input bit clr);
        bus.ce_i          = ce;
        bus.run_i         = run;
        bus.trig_i        = trig;
        bus.holdoff_len_i = HW'(len);
        bus.done_i        = done;
        bus.cnt_clear_i   = clr;
        @(posedge clk);
        model_step(ce, run, trig, len, done, clr);
        #1;
        check_all();
        bus.trig_i      = 1'b0;
        bus.done_i      = 1'b0;
        bus.cnt_clear_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bus.holdoff_o; k++) tick(1, 1, 0, 0, 0, 0);
        chk("idle_wait", bus.holdoff_o, 0);
    endtask

    initial begin
        int idx;
        int cnt;
        int dc0;
        bus.ce_i          = 1'b0;
        bus.run_i         = 1'b0;
        bus.trig_i        = 1'b0;
        bus.holdoff_len_i = '0;
        bus.done_i        = 1'b0;
        bus.cnt_clear_i   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #2 rst = 1'b0;

        // Arm, then first trigger.
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 1, 5, 0, 0);
        chk("first_trig_o", bus.trig_o, 1);
        chk("first_count", bus.trig_count_o, 1);
        chk("first_holdoff", bus.holdoff_o, 1);

        // Holdoff of 5 spends 6 ticks; next accept on the 7th.
        idx = -1;
        for (int k = 1; k <= 10; k++) begin
            tick(1, 1, 1, 5, 0, 0);
            if (bus.trig_o && idx < 0) idx = k;
        end
        chk("holdoff5_gap", idx, 7);
        wait_idle();

        // Zero-length holdoff: one tick, accept on the 2nd.
        tick(1, 1, 1, 0, 0, 0);
        idx = -1;
        for (int k = 1; k <= 5; k++) begin
            tick(1, 1, 1, 0, 0, 0);
            if (bus.trig_o && idx < 0) idx = k;
        end
        chk("holdoff0_gap", idx, 2);
        chk("full_dead", bus.dead_o, 1);
        chk("full_occ", bus.occupancy_o, NBUF);

        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1, 1, 1, 0, 0, 0);
            cnt += int'(bus.trig_o);
        end
        chk("full_drop", cnt, 0);
        tick(1, 1, 0, 0, 1, 0);
        chk("done_undead", bus.dead_o, 0);
        chk("done_occ", bus.occupancy_o, 3);

        // Accept and done together at occupancy 2.
        tick(1, 1, 0, 0, 1, 0);
        tick(1, 1, 1, 0, 1, 0);
        chk("acc_done_trig", bus.trig_o, 1);
        chk("acc_done_occ", bus.occupancy_o, 2);
        wait_idle();

        // done_i honoured with ce low; underflow at zero.
        tick(0, 1, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 0);
        chk("drain_occ", bus.occupancy_o, 0);
        tick(0, 1, 0, 0, 1, 0);
        chk("uflow_set", bus.underflow_o, 1);
        chk("uflow_occ", bus.occupancy_o, 0);

        // Disarm mid-holdoff, deadtime counting and saturation.
        tick(1, 1, 1, 100, 0, 0);
        tick(1, 1, 0, 100, 0, 0);
        tick(1, 0, 0, 100, 0, 0);
        chk("disarm_dead", bus.dead_o, 1);
        chk("disarm_hold", bus.holdoff_o, 0);
        dc0 = int'(bus.dead_count_o);
        repeat (3) tick(1, 0, 0, 0, 0, 0);
        chk("dead_inc3", bus.dead_count_o, dc0 + 3);
        repeat (CMAX + 20) tick(1, 0, 0, 0, 0, 0);
        chk("dead_sat", bus.dead_count_o, CMAX);
        tick(1, 0, 0, 0, 0, 1);
        chk("clr_dead", bus.dead_count_o, 0);
        chk("clr_trig", bus.trig_count_o, 0);

        // Asynchronous reset in the middle of a holdoff.
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 1, 50, 0, 0);
        tick(1, 1, 0, 50, 0, 0);
        chk("pre_rst_hold", bus.holdoff_o, 1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_trig_o", bus.trig_o, 0);
        chk("rst_dead_o", bus.dead_o, 1);
        #2 rst = 1'b0;

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            tick(($urandom_range(3) != 0),
                 ($urandom_range(19) != 0),
                 ($urandom_range(9) < 3),
                 int'($urandom_range(7)),
                 ($urandom_range(19) < 3),
                 ($urandom_range(99) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
